// File: rtl/rgb_fade_seq.sv
// Six-colour palette sequencer feeding the RGB PWM comparator: holds each colour
// for HOLD_TICKS ticks, then fades one LSB per tick per channel toward the next.
module rgb_fade_seq #(
    parameter int unsigned TICK_DIV   = 12000,
    parameter int unsigned HOLD_TICKS = 500
) (
    input  logic       iclk,
    input  logic       irst,
    input  logic       inext,
    input  logic       ipause,
    output logic [7:0] owvduty_r,
    output logic [7:0] owvduty_g,
    output logic [7:0] owvduty_b,
    output logic [2:0] owvidx,
    output logic       ostep,
    output logic       ofading
);
    localparam logic [0:0]  ST_HOLD   = 1'b0;
    localparam logic [0:0]  ST_FADE   = 1'b1;
    localparam logic [31:0] TICK_LAST = 32'(TICK_DIV - 1);
    localparam logic [15:0] HOLD_LAST = 16'(HOLD_TICKS - 1);

    logic [31:0] r_tcnt;
    logic [0:0]  r_state;
    logic [15:0] r_hcnt;
    logic [2:0]  r_idx;
    logic [2:0]  r_tidx;
    logic [7:0]  r_duty_r;
    logic [7:0]  r_duty_g;
    logic [7:0]  r_duty_b;
    logic        r_step;

    logic        w_tick;
    logic [23:0] w_cur_duty;
    logic [23:0] w_target;
    logic [23:0] w_fade_duty;
    logic [0:0]  w_nxt_state;
    logic [15:0] w_nxt_hcnt;
    logic [2:0]  w_nxt_idx;
    logic [2:0]  w_nxt_tidx;
    logic [23:0] w_nxt_duty;
    logic        w_nxt_step;

    function automatic logic [23:0] pal_color(input logic [2:0] idx);
        logic [23:0] c;
        case (idx)
            3'd0:    c = 24'hFF0000;
            3'd1:    c = 24'hFFFF00;
            3'd2:    c = 24'h00FF00;
            3'd3:    c = 24'h00FFFF;
            3'd4:    c = 24'h0000FF;
            3'd5:    c = 24'hFF00FF;
            default: c = 24'hFF0000;
        endcase
        return c;
    endfunction

    function automatic logic [2:0] idx_inc(input logic [2:0] idx);
        logic [2:0] n;
        if (idx >= 3'd5) begin
            n = 3'd0;
        end else begin
            n = idx + 3'd1;
        end
        return n;
    endfunction

    // Never overshoots the target, so no saturation logic is needed.
    function automatic logic [7:0] step_toward(input logic [7:0] cur, input logic [7:0] tgt);
        logic [7:0] n;
        if (cur < tgt) begin
            n = cur + 8'd1;
        end else if (cur > tgt) begin
            n = cur - 8'd1;
        end else begin
            n = cur;
        end
        return n;
    endfunction

    assign w_tick      = (r_tcnt == TICK_LAST) && !ipause;
    assign w_cur_duty  = {r_duty_r, r_duty_g, r_duty_b};
    assign w_target    = pal_color(r_tidx);
    assign w_fade_duty = {step_toward(r_duty_r, w_target[23:16]),
                          step_toward(r_duty_g, w_target[15:8]),
                          step_toward(r_duty_b, w_target[7:0])};

    // Tick divider: frozen while paused, wraps at TICK_DIV-1.
    always_ff @(posedge iclk) begin
        if (irst) begin
            r_tcnt <= 32'd0;
        end else if (ipause) begin
            r_tcnt <= r_tcnt;
        end else if (r_tcnt >= TICK_LAST) begin
            r_tcnt <= 32'd0;
        end else begin
            r_tcnt <= r_tcnt + 32'd1;
        end
    end

    // Next-state logic; an advance request outranks a coincident tick.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_hcnt  = r_hcnt;
        w_nxt_idx   = r_idx;
        w_nxt_tidx  = r_tidx;
        w_nxt_duty  = w_cur_duty;
        if (inext) begin
            if (r_state == ST_HOLD) begin
                w_nxt_state = ST_FADE;
                w_nxt_tidx  = idx_inc(r_idx);
                w_nxt_hcnt  = 16'd0;
            end else begin
                w_nxt_state = ST_HOLD;
                w_nxt_duty  = w_target;
                w_nxt_idx   = r_tidx;
                w_nxt_hcnt  = 16'd0;
            end
        end else if (w_tick) begin
            case (r_state)
                ST_HOLD: begin
                    if (r_hcnt >= HOLD_LAST) begin
                        w_nxt_state = ST_FADE;
                        w_nxt_tidx  = idx_inc(r_idx);
                    end else begin
                        w_nxt_hcnt = r_hcnt + 16'd1;
                    end
                end
                ST_FADE: begin
                    w_nxt_duty = w_fade_duty;
                    if (w_fade_duty == w_target) begin
                        w_nxt_state = ST_HOLD;
                        w_nxt_idx   = r_tidx;
                        w_nxt_hcnt  = 16'd0;
                    end else begin
                        w_nxt_state = ST_FADE;
                    end
                end
                default: begin
                    w_nxt_state = ST_HOLD;
                    w_nxt_hcnt  = 16'd0;
                end
            endcase
        end else begin
            w_nxt_state = r_state;
        end
        w_nxt_step = (w_nxt_duty != w_cur_duty);
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge iclk) begin
        if (irst) begin
            r_state  <= ST_HOLD;
            r_hcnt   <= 16'd0;
            r_idx    <= 3'd0;
            r_tidx   <= 3'd1;
            r_duty_r <= 8'hFF;
            r_duty_g <= 8'h00;
            r_duty_b <= 8'h00;
            r_step   <= 1'b0;
        end else begin
            r_state  <= w_nxt_state;
            r_hcnt   <= w_nxt_hcnt;
            r_idx    <= w_nxt_idx;
            r_tidx   <= w_nxt_tidx;
            r_duty_r <= w_nxt_duty[23:16];
            r_duty_g <= w_nxt_duty[15:8];
            r_duty_b <= w_nxt_duty[7:0];
            r_step   <= w_nxt_step;
        end
    end

    assign owvduty_r = r_duty_r;
    assign owvduty_g = r_duty_g;
    assign owvduty_b = r_duty_b;
    assign owvidx    = r_idx;
    assign ostep     = r_step;
    assign ofading   = (r_state == ST_FADE);

endmodule

// File: doc/rgb_fade_seq.md
# rgb_fade_seq

Colour-sequencer stage that sits directly upstream of the RGB PWM comparator. It walks a fixed six-colour palette, holding each colour and then fading linearly to the next one. It drives one 8-bit duty value per channel, and the PWM stage compares (scales) these against its sawtooth. An optional single-cycle `inext` pulse, taken from an already-debounced key, forces an early advance.

## Interface
- `TICK_DIV`, 12_000 — clock cycles per sequencer tick (1 kHz at 12 MHz). Legal range is 1 or more; 1 means a tick every cycle.
- `HOLD_TICKS`, 500 — number of ticks each palette colour is held before fading starts. Legal range is 1 to 65535.
- `iclk`  in  1  system clock; the block has one clock domain.
- `irst`  in  1  reset, synchronous and active-high.
- `inext`  in  1  single-cycle advance request (debounced key pulse).
- `ipause`  in  1  level input; while high, the tick generator is frozen.
- `owvduty_r`  out  8  red duty (0x00 = off, 0xFF = full).
- `owvduty_g`  out  8  green duty.
- `owvduty_b`  out  8  blue duty.
- `owvidx`  out  3  index of the last colour fully reached (0..5).
- `ostep`  out  1  one-cycle pulse, high in the cycle in which the duty outputs hold a newly stepped value.
- `ofading`  out  1  high while the state is FADE.

## Operation
- The palette is fixed (idx: R,G,B):
  - 0: FF,00,00
  - 1: FF,FF,00
  - 2: 00,FF,00
  - 3: 00,FF,FF
  - 4: 00,00,FF
  - 5: FF,00,FF
  - Index wraps 5 → 0.
- Tick generator:
  - 32-bit counter runs 0..TICK_DIV-1 and then wraps to 0.
  - The internal tick is high in the cycle where count == TICK_DIV-1 and `ipause` == 0.
  - While `ipause` == 1 the counter holds its value and no tick is generated.
- The FSM has two states, HOLD and FADE. It also keeps a 16-bit hold counter `hcnt` and a target index `tidx`.
- HOLD:
  - On a tick with hcnt < HOLD_TICKS-1: hcnt is incremented.
  - On a tick with hcnt == HOLD_TICKS-1: go to FADE, with tidx = (idx+1) mod 6.
- FADE, on each tick:
  - Each channel moves exactly 1 toward the palette value at tidx (+1, -1 or unchanged).
  - If all three channels equal the target after the step: go to HOLD, set idx = tidx, set hcnt = 0.
  - The transition happens on the same edge as the final step.
- `inext` in HOLD: go to FADE on the next edge, with tidx = (idx+1) mod 6 and hcnt = 0. No duty step is taken on that edge.
- `inext` in FADE: snap all duties to the palette value at tidx, set idx = tidx, go to HOLD, set hcnt = 0. `ostep` pulses.
- If `inext` and a tick occur in the same cycle, `inext` takes priority and the tick has no FSM effect. The tick counter still wraps normally.
- `inext` is honoured while `ipause` == 1.
- `ostep` is asserted for one cycle after every edge that changes any duty value (a fade step or a snap). It is not asserted for a step that leaves all three channels unchanged; such a step cannot occur between adjacent palette entries.
- Arithmetic:
  - Duty values are unsigned 8-bit and saturating by construction: a channel never steps past its target, so no wrap-around is possible.
  - Channels that already equal the target are unchanged.
- Values on reset (`irst` = 1 at a rising edge):
  - state = HOLD, idx = 0, tidx = 1.
  - Duty outputs = FF,00,00.
  - hcnt = 0, tick counter = 0.
  - `ostep` = 0, `ofading` = 0.
- Reset asserted mid-fade abandons the fade immediately; there is no partial-state retention.

## Timing
- All outputs are registered and change only on rising edges of `iclk`. Nothing is driven combinationally from inputs to outputs.
- Tick-to-output latency: the duty update is visible in the cycle after the tick cycle, and `ostep` is high in that same cycle.
- Hold duration is exactly HOLD_TICKS ticks, i.e. HOLD_TICKS × TICK_DIV cycles when not paused.
- Every adjacent palette pair differs in exactly one channel by 0xFF, so a full fade is 255 ticks.
- One full palette loop = 6 × (HOLD_TICKS + 255) ticks.
- `inext` response:
  - FSM state changes one edge after the `inext` cycle.
  - A snap is visible on the duty outputs one cycle later.
- `ofading` tracks the state register: it is high in the cycles after the HOLD→FADE edge, up to and including the edge on which the final step or snap is taken.

## Test plan
- Reset, with TICK_DIV=1 and HOLD_TICKS=4: hold `irst` high for 3 edges, then release → duties = FF,00,00, `owvidx` = 0, `ofading` = 0, `ostep` = 0.
- Free run with TICK_DIV=1, HOLD_TICKS=4:
  - `ofading` rises after edge 4.
  - `owvduty_g` increments by 1 per cycle.
  - G reaches 0xFF, `owvidx` = 1 and `ofading` = 0 after edge 259.
  - After edge 1554, duties are back to FF,00,00 with idx = 0.
- Tick divider with TICK_DIV=5: count the cycles between consecutive `ostep` pulses during FADE → exactly 5 every time.
- Pause during fade, TICK_DIV=1: hold `ipause` high for 20 cycles → duties and `ostep` stay frozen. On release, stepping resumes from the frozen value, and the fade completes 20 cycles later than it would have without the pause.
- Early advance with `inext`:
  - `inext` pulse during HOLD at idx 2 → `ofading` = 1 on the next edge, and B ramps from 00 toward FF.
  - A second `inext` mid-fade → duties snap to 00,FF,FF, idx = 3, one `ostep` pulse, state HOLD with hcnt = 0.
- Simultaneous events and reset mid-fade:
  - `inext` coincident with a tick in HOLD → exactly one transition, and hcnt is not incremented.
  - `irst` at the 100th fade step → the next cycle shows FF,00,00, idx = 0, `ofading` = 0.
